// File: rtl/i2s_rx_if.sv
// I2S receiver bundle: serial pins in, sample pair and frame strobe out.
// The master modport drives the pins; the slave modport is the receiver.
interface i2s_rx_if #(
   parameter int SAMPLE_WIDTH = 16
);
   logic                    bck;
   logic                    lrck;
   logic                    din;
   logic [SAMPLE_WIDTH-1:0] left;
   logic [SAMPLE_WIDTH-1:0] right;
   logic                    valid;
   logic                    frame_err;

   modport master (
      output bck, lrck, din,
      input  left, right, valid, frame_err
   );

   modport slave (
      input  bck, lrck, din,
      output left, right, valid, frame_err
   );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples bck/lrck/din in the clk domain and
// publishes one left/right pair per frame with a single-cycle strobe.
module i2s_rx #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int CNT_BITS     = 6
) (
   input logic     clk,
   input logic     arst_n,
   i2s_rx_if.slave bus
);

   localparam int SW = SAMPLE_WIDTH;
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_ALIGN,
      ST_WAIT_L,
      ST_ARMED
   } state_t;

   logic [SYNC_STAGES-1:0] bck_sync;
   logic [SYNC_STAGES-1:0] lrck_sync;
   logic [SYNC_STAGES-1:0] din_sync;
   logic                   bck_q;
   logic                   bck_s;
   logic                   lrck_s;
   logic                   din_s;
   logic                   rise;

   logic [SW-1:0]          shreg;
   logic [SW-1:0]          shreg_bit;
   logic [CNT_BITS-1:0]    bit_cnt;
   logic [CNT_BITS:0]      slot_bits;
   logic                   lrck_prev;
   logic                   boundary;
   logic                   short_slot;

   logic [SW-1:0]          left_hold;
   logic                   lshort;
   state_t                 state_q;
   state_t                 state_d;
   logic                   take_left;
   logic                   publish;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         bck_sync  <= '0;
         lrck_sync <= '0;
         din_sync  <= '0;
         bck_q     <= 1'b0;
      end else begin
         bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bus.bck};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], bus.lrck};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], bus.din};
         bck_q     <= bck_s;
      end
   end

   assign bck_s  = bck_sync[SYNC_STAGES-1];
   assign lrck_s = lrck_sync[SYNC_STAGES-1];
   assign din_s  = din_sync[SYNC_STAGES-1];
   assign rise   = bck_s & ~bck_q;

   // Bit j of a slot lands at shreg[SW-1-j]; bits beyond SW are dropped.
   always_comb begin
      shreg_bit = shreg;
      for (int i = 0; i < SW; i++) begin
         if (int'(bit_cnt) == SW - 1 - i) begin
            shreg_bit[i] = din_s;
         end
      end
      slot_bits  = {1'b0, bit_cnt} + {{CNT_BITS{1'b0}}, 1'b1};
      short_slot = int'(slot_bits) < SW;
      boundary   = rise & (lrck_s != lrck_prev);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         lrck_prev <= 1'b0;
      end else if (boundary) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         lrck_prev <= lrck_s;
      end else if (rise) begin
         shreg <= shreg_bit;
         if (bit_cnt != CNT_MAX) begin
            bit_cnt <= bit_cnt + CNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_ALIGN;
      end else begin
         state_q <= state_d;
      end
   end

   // The first boundary after reset only aligns; a left slot must close
   // before the following right slot may publish a pair.
   always_comb begin
      state_d   = state_q;
      take_left = 1'b0;
      publish   = 1'b0;
      if (boundary) begin
         unique case (state_q)
            ST_ALIGN: begin
               state_d = ST_WAIT_L;
            end
            ST_WAIT_L: begin
               if (lrck_s) begin
                  take_left = 1'b1;
                  state_d   = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (lrck_s) begin
                  take_left = 1'b1;
               end else begin
                  publish = 1'b1;
                  state_d = ST_WAIT_L;
               end
            end
            default: begin
               state_d = ST_ALIGN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         left_hold     <= '0;
         lshort        <= 1'b0;
         bus.left      <= '0;
         bus.right     <= '0;
         bus.frame_err <= 1'b0;
         bus.valid     <= 1'b0;
      end else begin
         bus.valid <= publish;
         if (take_left) begin
            left_hold <= shreg_bit;
            lshort    <= short_slot;
         end
         if (publish) begin
            bus.left      <= left_hold;
            bus.right     <= shreg_bit;
            bus.frame_err <= lshort | short_slot;
         end
      end
   end

endmodule
